// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request bus between the two writeback producers (ALU result and
// memory load) and the register-file write-port arbiter.
//
// Handshake: a producer raises *_valid with *_addr/*_data and holds all three
// steady until the cycle in which *_ready is also 1; that cycle is the transfer.
// *_ready is computed by the arbiter without looking at the same producer's
// *_valid, so a producer may sample ready before deciding to request.
//
// Modports:
//   master - a writeback producer side (drives valid/addr/data, sees ready)
//   slave  - the arbiter side (sees valid/addr/data, drives ready)
interface regfile_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              alu_valid;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_ready;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the register file's single write port between ALU writeback and
// memory-load writeback, and keeps a pending-write scoreboard for R0-R14 so
// decode can stall on read-after-write hazards.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   wb (slave)          ALU and MEM writeback requests with valid/ready
//   iss_valid/iss_addr  decode issues an instruction that will write iss_addr
//   chk_a1/chk_a2       source registers of the instruction in decode
//   hazard              a source register has a pending write (combinational)
//   we3/wa3/wd3         registered regfile write port
//   err_r15             one-cycle pulse: an accepted write to R15 was dropped
//   stat_conflict/stat_r15  (only with RF_ARB_STATS_EN) saturating counters of
//                       contended cycles and dropped R15 writes
//
// Optional feature macro: RF_ARB_STATS_EN.
//
// The arbiter is stateless apart from the streak counter, which counts
// consecutive contended cycles won by MEM. STARVE_MAX must be at least 1.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  regfile_wb_arbiter_if.slave wb,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic [ADDR_W-1:0] chk_a1,
  input  logic [ADDR_W-1:0] chk_a2,
  output logic              hazard,
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              err_r15
`ifdef RF_ARB_STATS_EN
  ,
  output logic [15:0]       stat_conflict,
  output logic [15:0]       stat_r15
`endif
);

  localparam int              NREG = (1 << ADDR_W) - 1;
  localparam logic [ADDR_W-1:0] R15 = '1;
  localparam int              SW   = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   SMAX = SW'(STARVE_MAX);

  logic [SW-1:0]     streak;
  logic [NREG-1:0]   pend;
  logic [NREG-1:0]   pend_set;
  logic [NREG-1:0]   pend_clr;

  logic              contended;
  logic              alu_turn;
  logic              alu_acc;
  logic              mem_acc;
  logic              acc;
  logic              acc_r15;
  logic              acc_wr;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_data;

  // Each ready is what that requester would get if it were valid, so it only
  // looks at the other side's valid. When both are valid exactly one ready is
  // high; with neither valid both may be high, which transfers nothing.
  assign contended    = wb.alu_valid && wb.mem_valid;
  assign alu_turn     = (streak >= SMAX);
  assign wb.alu_ready = !wb.mem_valid || alu_turn;
  assign wb.mem_ready = !wb.alu_valid || !alu_turn;

  assign alu_acc  = wb.alu_valid && wb.alu_ready;
  assign mem_acc  = wb.mem_valid && wb.mem_ready;
  assign acc      = alu_acc || mem_acc;
  assign acc_addr = alu_acc ? wb.alu_addr : wb.mem_addr;
  assign acc_data = alu_acc ? wb.alu_data : wb.mem_data;
  assign acc_r15  = acc && (acc_addr == R15);
  assign acc_wr   = acc && (acc_addr != R15);

  // Streak of contended MEM wins; any ALU win restarts it, uncontended MEM
  // grants leave it alone. It never exceeds SMAX because MEM cannot win a
  // contended cycle once it reaches SMAX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak <= '0;
    end else if (alu_acc) begin
      streak <= '0;
    end else if (mem_acc && contended && (streak < SMAX)) begin
      streak <= streak + 1'b1;
    end
  end

  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (iss_valid && (iss_addr != R15)) pend_set[iss_addr] = 1'b1;
    if (acc_wr)                         pend_clr[acc_addr] = 1'b1;
  end

  // Clear is applied first so a same-cycle issue to the register wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend <= '0;
    else       pend <= (pend & ~pend_clr) | pend_set;
  end

  // The register is cleared on its accept edge; the regfile writes mid-cycle
  // on the following negedge, so decode can read it without stalling.
  always_comb begin
    hazard = 1'b0;
    if ((chk_a1 != R15) && pend[chk_a1]) hazard = 1'b1;
    if ((chk_a2 != R15) && pend[chk_a2]) hazard = 1'b1;
  end

  // wa3/wd3 only move on a real write, so they hold across idle and R15 cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we3     <= 1'b0;
      wa3     <= '0;
      wd3     <= '0;
      err_r15 <= 1'b0;
    end else begin
      we3     <= acc_wr;
      err_r15 <= acc_r15;
      if (acc_wr) begin
        wa3 <= acc_addr;
        wd3 <= acc_data;
      end
    end
  end

`ifdef RF_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_conflict <= '0;
      stat_r15      <= '0;
    end else begin
      if (contended && (stat_conflict != 16'hFFFF)) stat_conflict <= stat_conflict + 16'd1;
      if (acc_r15 && (stat_r15 != 16'hFFFF))        stat_r15      <= stat_r15 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 4;
  localparam int STARVE_MAX = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic [ADDR_W-1:0] chk_a1;
  logic [ADDR_W-1:0] chk_a2;
  logic              hazard;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic              err_r15;
`ifdef RF_ARB_STATS_EN
  logic [15:0]       stat_conflict;
  logic [15:0]       stat_r15;
`endif

  regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) wb ();

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .wb(wb),
    .iss_valid(iss_valid),
    .iss_addr(iss_addr),
    .chk_a1(chk_a1),
    .chk_a2(chk_a2),
    .hazard(hazard),
    .we3(we3),
    .wa3(wa3),
    .wd3(wd3),
    .err_r15(err_r15)
`ifdef RF_ARB_STATS_EN
    ,
    .stat_conflict(stat_conflict),
    .stat_r15(stat_r15)
`endif
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Pending writes as a plain bit per register, the starvation rule as a count
  // of consecutive contended MEM wins, and the write port as "whatever was
  // accepted last cycle".
  bit                pend_m [15];
  int                mem_streak;
  logic              exp_we3;
  logic              exp_err;
  logic [ADDR_W-1:0] exp_wa3;
  logic [DATA_W-1:0] exp_wd3;
  int                exp_sc;
  int                exp_sr;
  bit                m_aw, m_mw, m_both;
  logic [ADDR_W-1:0] m_a;
  logic [DATA_W-1:0] m_d;
  logic [ADDR_W+DATA_W-1:0] m_e;

  function automatic bit pend_of(input logic [ADDR_W-1:0] r);
    if (r == 4'hF) return 1'b0;
    return pend_m[r];
  endfunction

  always @(negedge clk) begin : compare
    if (reset) begin
      check("rst_we3", we3, 0);
      check("rst_hazard", hazard, 0);
      foreach (pend_m[i]) pend_m[i] = 1'b0;
      mem_streak = 0;
      exp_we3 = 1'b0;
      exp_err = 1'b0;
      exp_wa3 = '0;
      exp_wd3 = '0;
      exp_sc = 0;
      exp_sr = 0;
      exp_q.delete();
    end else begin
      // outputs produced by the previous posedge
      check("we3", we3, exp_we3);
      check("err_r15", err_r15, exp_err);
      check("wa3", wa3, exp_wa3);
      check("wd3", wd3, exp_wd3);
`ifdef RF_ARB_STATS_EN
      check("stat_conflict", stat_conflict, exp_sc);
      check("stat_r15", stat_r15, exp_sr);
`endif
      if (we3 === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL wb_extra_write: got write %0h<=%0h expected none at %0t", wa3, wd3, $time);
        end else begin
          m_e = exp_q.pop_front();
          check("wb_data", {wa3, wd3}, m_e);
        end
      end
      check("hazard", hazard, pend_of(chk_a1) || pend_of(chk_a2));

      // who wins this cycle
      m_both = wb.alu_valid && wb.mem_valid;
      m_aw = 1'b0;
      m_mw = 1'b0;
      if (m_both) begin
        if (mem_streak >= STARVE_MAX) m_aw = 1'b1;
        else                          m_mw = 1'b1;
      end else if (wb.alu_valid) begin
        m_aw = 1'b1;
      end else if (wb.mem_valid) begin
        m_mw = 1'b1;
      end
      if (wb.alu_valid) check("alu_ready", wb.alu_ready, m_aw);
      if (wb.mem_valid) check("mem_ready", wb.mem_ready, m_mw);

      // advance to the next posedge
      if (m_aw)                mem_streak = 0;
      else if (m_mw && m_both) mem_streak++;
      exp_we3 = 1'b0;
      exp_err = 1'b0;
      if (m_aw || m_mw) begin
        m_a = m_aw ? wb.alu_addr : wb.mem_addr;
        m_d = m_aw ? wb.alu_data : wb.mem_data;
        if (m_a == 4'hF) begin
          exp_err = 1'b1;
          if (exp_sr < 65535) exp_sr++;
        end else begin
          exp_we3 = 1'b1;
          exp_wa3 = m_a;
          exp_wd3 = m_d;
          exp_q.push_back({m_a, m_d});
          pend_m[m_a] = 1'b0;
        end
      end
      if (iss_valid && iss_addr != 4'hF) pend_m[iss_addr] = 1'b1;
      if (m_both && exp_sc < 65535) exp_sc++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Finish the current cycle, reporting which requester transferred.
  task automatic edge_acc(output bit a_acc, output bit m_acc);
    @(negedge clk);
    a_acc = wb.alu_valid && wb.alu_ready;
    m_acc = wb.mem_valid && wb.mem_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    wb.alu_valid = 1'b0;
    wb.alu_addr  = '0;
    wb.alu_data  = '0;
    wb.mem_valid = 1'b0;
    wb.mem_addr  = '0;
    wb.mem_data  = '0;
    iss_valid    = 1'b0;
    iss_addr     = '0;
    chk_a1       = '0;
    chk_a2       = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    bit a, m;
    byte g;
    string order;
    reset = 1'b1;
    clear_inputs();
    do_reset();

    // reset values
    check("init_we3", we3, 0);
    check("init_wa3", wa3, 0);
    check("init_wd3", wd3, 0);
    check("init_err", err_r15, 0);
    check("init_hazard", hazard, 0);

    // 1) ALU only
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 4'd3;
    wb.alu_data  = 32'h1234;
    #1;
    check("t1_alu_ready", wb.alu_ready, 1);
    edge_acc(a, m);
    wb.alu_valid = 1'b0;
    check("t1_we3", we3, 1);
    check("t1_wa3", wa3, 3);
    check("t1_wd3", wd3, 32'h1234);
    tick();
    check("t1_we3_off", we3, 0);
    check("t1_wa3_hold", wa3, 3);

    // 2) both valid for six cycles
    do_reset();
    order = "MMMAMM";
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 4'd1;
    wb.alu_data  = 32'hA000;
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 4'd2;
    wb.mem_data  = 32'hB000;
    for (int i = 0; i < 6; i++) begin
      #1;
      g = wb.mem_ready ? 8'h4D : (wb.alu_ready ? 8'h41 : 8'h2D);
      check("t2_grant", g, order[i]);
      check("t2_one_ready", wb.alu_ready && wb.mem_ready, 0);
      edge_acc(a, m);
      if (a) wb.alu_data = wb.alu_data + 1;
      if (m) wb.mem_data = wb.mem_data + 1;
    end
    wb.alu_valid = 1'b0;
    wb.mem_valid = 1'b0;
    tick();

    // 3) scoreboard
    do_reset();
    chk_a1 = 4'd5;
    chk_a2 = 4'd0;
    iss_valid = 1'b1;
    iss_addr  = 4'd5;
    tick();
    iss_valid = 1'b0;
    check("t3_hazard_set", hazard, 1);
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 4'd5;
    wb.mem_data  = 32'd55;
    edge_acc(a, m);
    wb.mem_valid = 1'b0;
    check("t3_hazard_clr", hazard, 0);
    check("t3_we3", we3, 1);
    iss_valid    = 1'b1;
    iss_addr     = 4'd5;
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 4'd5;
    wb.mem_data  = 32'd56;
    edge_acc(a, m);
    iss_valid    = 1'b0;
    wb.mem_valid = 1'b0;
    check("t3_set_wins", hazard, 1);

    // 4) R15
    do_reset();
    chk_a1 = 4'hF;
    chk_a2 = 4'hF;
    wb.mem_valid = 1'b1;
    wb.mem_addr  = 4'hF;
    wb.mem_data  = 32'd99;
    #1;
    check("t4_mem_ready", wb.mem_ready, 1);
    edge_acc(a, m);
    wb.mem_valid = 1'b0;
    check("t4_we3", we3, 0);
    check("t4_err_on", err_r15, 1);
    tick();
    check("t4_err_off", err_r15, 0);
    iss_valid = 1'b1;
    iss_addr  = 4'hF;
    tick();
    iss_valid = 1'b0;
    check("t4_r15_no_hazard", hazard, 0);

    // 5) asynchronous reset in the middle of a write
    do_reset();
    chk_a1 = 4'd7;
    chk_a2 = 4'hF;
    iss_valid    = 1'b1;
    iss_addr     = 4'd7;
    wb.alu_valid = 1'b1;
    wb.alu_addr  = 4'd3;
    wb.alu_data  = 32'd77;
    edge_acc(a, m);
    iss_valid    = 1'b0;
    wb.alu_valid = 1'b0;
    check("t5_pre_we3", we3, 1);
    check("t5_pre_hazard", hazard, 1);
    #1 reset = 1'b1;
    #1;
    check("t5_async_we3", we3, 0);
    check("t5_async_hazard", hazard, 0);
    @(posedge clk);
    #1 reset = 1'b0;

    // randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (!wb.alu_valid && $urandom_range(0, 99) < 60) begin
        wb.alu_valid = 1'b1;
        wb.alu_addr  = 4'($urandom_range(0, 15));
        wb.alu_data  = $urandom;
      end
      if (!wb.mem_valid && $urandom_range(0, 99) < 60) begin
        wb.mem_valid = 1'b1;
        wb.mem_addr  = 4'($urandom_range(0, 15));
        wb.mem_data  = $urandom;
      end
      iss_valid = ($urandom_range(0, 99) < 30);
      iss_addr  = 4'($urandom_range(0, 15));
      chk_a1    = 4'($urandom_range(0, 15));
      chk_a2    = 4'($urandom_range(0, 15));
      edge_acc(a, m);
      if (a) wb.alu_valid = 1'b0;
      if (m) wb.mem_valid = 1'b0;
    end
    clear_inputs();
    repeat (3) tick();
    check("drain_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
